// File: rtl/fsk_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// fsk_tx_scheduler_if
// Byte stream handshake between a byte producer and the FSK TX scheduler.
//   s_data  : byte to transmit (producer -> scheduler)
//   s_valid : s_data valid     (producer -> scheduler)
//   s_ready : scheduler FIFO can accept a byte (scheduler -> producer)
// A byte moves on a clk edge where s_valid && s_ready.
// ---------------------------------------------------------------------------
interface fsk_tx_scheduler_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fsk_tx_scheduler.sv
// ---------------------------------------------------------------------------
// fsk_tx_scheduler
// Buffers bytes from a producer, frames each as 8N1 UART and drives the FSK
// modulator's bit input at CLKS_PER_BIT clocks per bit. A mark preamble of
// PREAMBLE_BITS bit periods leads each burst; queued bytes follow back to back.
//
// Ports:
//   clk           : system clock (50 MHz)
//   rst_n         : asynchronous active-low reset, synchronous release
//   s_if (slave)  : byte stream in (s_data, s_valid, s_ready = not full)
//   o_uart_bit    : line level to the modulator, 1 = mark/idle, 0 = space
//   o_tx_active   : high from preamble start through last stop bit of a burst
//   o_frame_done  : one-cycle pulse in the final cycle of each stop bit
//   o_fifo_level  : number of buffered bytes
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line at mark, waiting for a buffered byte
// PREAMBLE | mark tone for PREAMBLE_BITS bit periods, start of a burst
// START    | start bit (space); head byte was popped on entry
// DATA     | 8 data bits, LSB first
// STOP     | stop bit (mark); next byte follows with no gap if queued
// ---------------------------------------------------------------------------
module fsk_tx_scheduler #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int FIFO_DEPTH    = 4,
  parameter int PREAMBLE_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  fsk_tx_scheduler_if.slave             s_if,
  output logic                          o_uart_bit,
  output logic                          o_tx_active,
  output logic                          o_frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Bit counter serves both the preamble and the 8 data bits.
  localparam int BIT_W = $clog2((PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(7);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  // FSM
  state_t           r_state;
  logic [CNT_W-1:0] r_baud;
  logic [BIT_W-1:0] r_bit;
  logic [7:0]       r_shreg;
  logic             r_uart;
  logic             r_active;
  logic             r_done;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_baud_end;
  logic [7:0]       w_head;

  assign w_full     = (r_level == LVL_FULL);
  assign w_empty    = (r_level == '0);
  assign w_push     = s_if.s_valid && !w_full;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_baud_end = (r_baud == BAUD_LAST);

  assign s_if.s_ready = !w_full;
  assign o_fifo_level = r_level;
  assign o_uart_bit   = r_uart;
  assign o_tx_active  = r_active;
  assign o_frame_done = r_done;

  // A pop coincides exactly with every transition into START.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:     w_pop = (PREAMBLE_BITS == 0) && !w_empty;
      S_PREAMBLE: w_pop = w_baud_end && (r_bit == PRE_LAST);
      S_STOP:     w_pop = w_baud_end && !w_empty;
      default:    w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_if.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shreg  <= '0;
      r_uart   <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (!w_empty) begin
            r_active <= 1'b1;
            if (w_pop) begin
              r_state <= S_START;
              r_shreg <= w_head;
              r_uart  <= 1'b0;
            end else begin
              r_state <= S_PREAMBLE;
              r_uart  <= 1'b1;
            end
          end
        end

        S_PREAMBLE: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == PRE_LAST) begin
              r_bit   <= '0;
              r_state <= S_START;
              r_shreg <= w_head;
              r_uart  <= 1'b0;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end

        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_uart  <= r_shreg[0];
            r_shreg <= {1'b0, r_shreg[7:1]};
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == DATA_LAST) begin
              r_bit   <= '0;
              r_state <= S_STOP;
              r_uart  <= 1'b1;
            end else begin
              r_bit   <= r_bit + BIT_W'(1);
              r_uart  <= r_shreg[0];
              r_shreg <= {1'b0, r_shreg[7:1]};
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_state <= S_START;
              r_shreg <= w_head;
              r_uart  <= 1'b0;
            end else begin
              r_state  <= S_IDLE;
              r_uart   <= 1'b1;
              r_active <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
            // Registered pulse lands in the last cycle of the stop bit.
            if (r_baud == BAUD_PRE) r_done <= 1'b1;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_uart   <= 1'b1;
          r_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_tx_scheduler.sv
module tb_fsk_tx_scheduler;

  localparam int C   = 8;
  localparam int PB  = 2;
  localparam int D   = 4;
  localparam int FL  = 10 * C;
  localparam int CB  = 434;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsk_tx_scheduler_if if_a ();
  fsk_tx_scheduler_if if_b ();

  logic       o_uart_a, o_active_a, o_done_a;
  logic [2:0] o_level_a;
  logic       o_uart_b, o_active_b, o_done_b;
  logic [2:0] o_level_b;

  fsk_tx_scheduler #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .PREAMBLE_BITS(PB)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_if         (if_a),
    .o_uart_bit   (o_uart_a),
    .o_tx_active  (o_active_a),
    .o_frame_done (o_done_a),
    .o_fifo_level (o_level_a)
  );

  fsk_tx_scheduler #(.CLKS_PER_BIT(CB), .FIFO_DEPTH(D), .PREAMBLE_BITS(0)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_if         (if_b),
    .o_uart_bit   (o_uart_b),
    .o_tx_active  (o_active_b),
    .o_frame_done (o_done_b),
    .o_fifo_level (o_level_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of dut_a ----------------
  // Burst timeline: cycle t of a burst is mark for t < PB*C, then a 10*C
  // cycle frame repeats; each frame's byte leaves the queue at its first cycle.
  logic [7:0] m_q[$];
  bit         m_busy = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;
  int         m_pre_n;
  bit         m_acc;
  logic [7:0] m_din;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_busy = 1'b0;
      m_t = 0;
    end else begin
      m_pre_n = m_q.size();
      m_acc   = if_a.s_valid && (m_pre_n < D);
      m_din   = if_a.s_data;
      if (!m_busy) begin
        if (m_pre_n > 0) begin
          m_busy = 1'b1;
          m_t = 0;
          if (PB == 0) m_cur = m_q.pop_front();
        end
      end else begin
        m_t++;
        if (m_t >= PB * C && ((m_t - PB * C) % FL) == 0) begin
          if (m_pre_n > 0) m_cur = m_q.pop_front();
          else m_busy = 1'b0;
        end
      end
      if (m_acc) m_q.push_back(m_din);
    end
  end

  int   e_r, e_b;
  logic e_uart, e_act, e_done;

  always @(negedge clk) begin
    if (!m_busy) begin
      e_uart = 1'b1; e_act = 1'b0; e_done = 1'b0;
    end else if (m_t < PB * C) begin
      e_uart = 1'b1; e_act = 1'b1; e_done = 1'b0;
    end else begin
      e_r = (m_t - PB * C) % FL;
      e_b = e_r / C;
      e_act  = 1'b1;
      e_uart = (e_b == 0) ? 1'b0 : (e_b <= 8) ? m_cur[e_b-1] : 1'b1;
      e_done = (e_r == FL - 1);
    end
    chk("cmp_uart_bit",   32'(o_uart_a),     32'(e_uart));
    chk("cmp_tx_active",  32'(o_active_a),   32'(e_act));
    chk("cmp_frame_done", 32'(o_done_a),     32'(e_done));
    chk("cmp_fifo_level", 32'(o_level_a),    32'(m_q.size()));
    chk("cmp_s_ready",    32'(if_a.s_ready), 32'(m_q.size() < D));
  end

  // ---------------- line history for hand checks ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  bit hist [8192];
  int done_q[$];
  always @(negedge clk) begin
    hist[cyc % 8192] = o_uart_a;
    if (o_done_a) done_q.push_back(cyc);
  end

  // ---------------- directed stimulus ----------------
  int         e1, f1, ok, dcnt, didx, acnt, act_low, nmatch, d;
  logic [7:0] dec;
  logic       ua [97];
  logic       ac [97];
  int         a5p [12] = '{1, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic [7:0] exp_bytes [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h55};
  int         zeros_b, first_one_b, done_idx_b, done_cnt_b, act_cnt_b;

  initial begin
    if_a.s_valid = 1'b0; if_a.s_data = 8'h00;
    if_b.s_valid = 1'b0; if_b.s_data = 8'h00;

    // Reset held with random input activity
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_a.s_valid = 1'($urandom_range(0, 1));
      if_a.s_data  = 8'($urandom);
    end
    chk("rst_uart_bit",   32'(o_uart_a),     32'd1);
    chk("rst_tx_active",  32'(o_active_a),   32'd0);
    chk("rst_frame_done", 32'(o_done_a),     32'd0);
    chk("rst_fifo_level", 32'(o_level_a),    32'd0);
    chk("rst_s_ready",    32'(if_a.s_ready), 32'd1);
    @(negedge clk);
    if_a.s_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte 0xA5
    if_a.s_valid = 1'b1; if_a.s_data = 8'hA5;
    @(negedge clk);
    if_a.s_valid = 1'b0;
    chk("a5_level_after_push", 32'(o_level_a), 32'd1);
    chk("a5_active_at_push",   32'(o_active_a), 32'd0);
    dcnt = 0; didx = -1; acnt = 0;
    for (int i = 0; i < 97; i++) begin
      @(negedge clk);
      ua[i] = o_uart_a;
      ac[i] = o_active_a;
      if (o_done_a) begin dcnt++; didx = i; end
      if (i < 96 && o_active_a) acnt++;
    end
    chk("a5_active_rise", 32'(ac[0]), 32'd1);
    chk("a5_active_len",  32'(acnt),  32'd96);
    chk("a5_active_fall", 32'(ac[96]), 32'd0);
    chk("a5_done_count",  32'(dcnt),  32'd1);
    chk("a5_done_index",  32'(didx),  32'd95);
    for (int k = 0; k < 12; k++) begin
      nmatch = 0;
      for (int j = 0; j < 8; j++) if (32'(ua[k*8+j]) == 32'(a5p[k])) nmatch++;
      chk($sformatf("a5_period%0d", k), 32'(nmatch), 32'd8);
    end
    repeat (4) @(negedge clk);

    // Fill, back-to-back frames and full backpressure
    done_q.delete();
    if_a.s_valid = 1'b1; if_a.s_data = 8'h01;
    @(negedge clk); e1 = cyc; if_a.s_data = 8'h02;
    @(negedge clk); if_a.s_data = 8'h03;
    @(negedge clk); if_a.s_data = 8'h04;
    @(negedge clk); if_a.s_data = 8'h55;
    chk("fill_level_full", 32'(o_level_a),    32'd4);
    chk("fill_ready_low",  32'(if_a.s_ready), 32'd0);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (if_a.s_ready) begin ok = cyc; break; end
    end
    chk("bp_ready_return_cycle", 32'(ok - e1), 32'd17);
    @(negedge clk);
    if_a.s_valid = 1'b0;
    ok = 0; act_low = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (done_q.size() >= 5) begin ok = 1; break; end
      if (!o_active_a) act_low++;
    end
    chk("burst_five_frames", 32'(ok), 32'd1);
    chk("burst_active_continuous", 32'(act_low), 32'd0);
    @(negedge clk);
    chk("burst_active_fall", 32'(o_active_a), 32'd0);
    if (done_q.size() >= 5) begin
      chk("burst_first_done", 32'(done_q[0] - e1), 32'd96);
      for (int k = 1; k < 5; k++)
        chk($sformatf("burst_done_gap%0d", k), 32'(done_q[k] - done_q[k-1]), 32'(FL));
      for (int k = 0; k < 5; k++) begin
        d = done_q[k];
        for (int j = 0; j < 8; j++) dec[j] = hist[(d - 79 + 8 * (1 + j) + 4) % 8192];
        chk($sformatf("burst_byte%0d", k), 32'(dec), 32'(exp_bytes[k]));
      end
    end
    repeat (4) @(negedge clk);

    // Reset during data bit 3 with two bytes still queued
    if_a.s_valid = 1'b1; if_a.s_data = 8'h96;
    @(negedge clk); f1 = cyc; if_a.s_data = 8'h11;
    @(negedge clk); if_a.s_data = 8'h22;
    @(negedge clk); if_a.s_valid = 1'b0;
    while (cyc < f1 + 52) @(negedge clk);
    chk("mid_bit3_space", 32'(o_uart_a),  32'd0);
    chk("mid_level_two",  32'(o_level_a), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_uart_mark", 32'(o_uart_a),     32'd1);
    chk("mid_rst_inactive",  32'(o_active_a),   32'd0);
    chk("mid_rst_level",     32'(o_level_a),    32'd0);
    chk("mid_rst_ready",     32'(if_a.s_ready), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    done_q.delete();
    acnt = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (o_active_a) acnt++;
    end
    chk("post_rst_no_done",   32'(done_q.size()), 32'd0);
    chk("post_rst_no_active", 32'(acnt),          32'd0);
    chk("post_rst_level",     32'(o_level_a),     32'd0);

    // No preamble, 434 clocks per bit, byte 0x00
    @(negedge clk);
    if_b.s_valid = 1'b1; if_b.s_data = 8'h00;
    @(negedge clk);
    if_b.s_valid = 1'b0;
    chk("b_idle_after_push", 32'(o_active_b), 32'd0);
    chk("b_level_one",       32'(o_level_b),  32'd1);
    zeros_b = 0; first_one_b = -1; done_idx_b = -1; done_cnt_b = 0; act_cnt_b = 0;
    for (int i = 0; i <= 10 * CB; i++) begin
      @(negedge clk);
      if (i < 10 * CB) begin
        if (!o_uart_b) zeros_b++;
        else if (first_one_b < 0) first_one_b = i;
        if (o_active_b) act_cnt_b++;
      end else begin
        chk("b_active_fall", 32'(o_active_b), 32'd0);
        chk("b_line_idle",   32'(o_uart_b),   32'd1);
      end
      if (o_done_b) begin done_cnt_b++; done_idx_b = i; end
    end
    chk("b_space_cycles", 32'(zeros_b),     32'd3906);
    chk("b_first_mark",   32'(first_one_b), 32'd3906);
    chk("b_active_len",   32'(act_cnt_b),   32'd4340);
    chk("b_done_count",   32'(done_cnt_b),  32'd1);
    chk("b_done_index",   32'(done_idx_b),  32'd4339);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsk_tx_scheduler.md
Name: fsk_tx_scheduler

Overview:
- Sequences the FSK modulator's uart_bit input: buffers bytes from a producer, frames each one as 8N1 UART, and drives bit levels at the baud rate derived from the 50 MHz clk.
- Inserts a mark-tone preamble at the start of each burst so the receiver demodulator can settle.
- Sits between the byte source (command or packet logic) and the modulator's uart_bit input; tx_active can gate the downstream RF/GPIO driver.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200 baud); legal range is 2 or more.
- FIFO_DEPTH, 4, byte buffer depth; must be a power of 2, 2 or more.
- PREAMBLE_BITS, 16, mark (1) bit periods sent before the first frame of a burst; 0 disables the preamble.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  8  byte to transmit.
- s_valid  input  1  s_data valid.
- s_ready  output  1  FIFO can accept; equals not-full, derived from registered state.
- uart_bit  output  1  bit level to the modulator; 1 = mark/idle, 0 = space.
- tx_active  output  1  high from preamble start through the last stop bit of a burst.
- frame_done  output  1  one-cycle pulse at the end of each stop bit.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current number of buffered bytes.

Behaviour:
- Reset: async assert when rst_n = 0; release is synchronous to clk.
  - While reset is asserted: uart_bit = 1, tx_active = 0, frame_done = 0, fifo_level = 0, s_ready = 1.
  - FIFO is flushed; FSM goes to IDLE; baud counter and bit counter are cleared.
- Push: on a clk edge where s_valid && s_ready, s_data is written at the tail.
  - When full, s_ready = 0 and s_data is ignored; no overwrite.
- Pop: only the FSM pops.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - A pop while full raises s_ready on the next cycle.
  - Order is strictly FIFO.
- Baud timing: each bit period is exactly CLKS_PER_BIT cycles. The counter runs from 0 to CLKS_PER_BIT-1, restarts on each state/bit change, and has no drift between bits.
- FSM states:
  - IDLE: uart_bit = 1, tx_active = 0. If fifo_level != 0, go to PREAMBLE (or to START if PREAMBLE_BITS = 0) at the next edge; tx_active = 1 from that edge.
  - PREAMBLE: uart_bit = 1 for PREAMBLE_BITS*CLKS_PER_BIT cycles, then go to START.
  - START: on entry, pop the head byte into the shift register. uart_bit = 0 for 1 bit period, then go to DATA.
  - DATA: 8 bit periods, LSB first; uart_bit = shreg[0], shifting right each period. Then go to STOP.
  - STOP: uart_bit = 1 for 1 bit period. frame_done pulses in the final cycle of the period. Then:
    - If fifo_level != 0, go to START back-to-back with no preamble and no idle gap.
    - Otherwise go to IDLE; tx_active falls at the same edge.
- Latency: a byte pushed into an empty FIFO in IDLE at edge T causes tx_active = 1 and the PREAMBLE start after edge T+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles, START entry to STOP exit.
- Burst length: PREAMBLE_BITS*CLKS_PER_BIT + n*10*CLKS_PER_BIT cycles for n back-to-back bytes.
- Bytes pushed during PREAMBLE or any frame state join the current burst.
- uart_bit, tx_active and frame_done are registered outputs; there is no combinational path from inputs to them.
- Reset mid-frame: the line returns to mark immediately (async), the partial frame is abandoned, and buffered bytes are discarded.

Test Plan:
- Bench overrides CLKS_PER_BIT = 8, PREAMBLE_BITS = 2 unless stated.
- Reset: hold rst_n = 0 with random s_valid -> uart_bit = 1, tx_active = 0, s_ready = 1, fifo_level = 0, frame_done = 0 throughout.
- Single byte 0xA5: push once -> tx_active rises 1 cycle later; uart_bit = 1 for 16 cycles, then 0 for 8; data bits 1,0,1,0,0,1,0,1 for 8 cycles each; stop 1 for 8; one frame_done; tx_active falls after 96 cycles total.
- Fill and back-to-back: push 0x01, 0x02, 0x03, 0x04 on consecutive cycles -> s_ready = 0 after the 4th push, fifo_level = 4. One preamble only, then 4 frames in order. frame_done pulses are 80 cycles apart, and tx_active stays high continuously.
- Full backpressure: hold s_valid with 0x55 while full -> not accepted until the first pop; it is transmitted 5th; no byte is lost or duplicated.
- Reset mid-DATA: assert rst_n = 0 during bit 3 of a frame with 2 bytes queued -> uart_bit = 1 the same cycle. After release: fifo_level = 0, and no frame_done or transmission follows.
- PREAMBLE_BITS = 0, CLKS_PER_BIT = 434: push 0x00 -> the START entry edge is 1 edge after the push edge. uart_bit = 0 for 9*434 cycles, then 1 for 434 cycles; frame_done is at cycle 4340 from START entry.
